// File: rtl/roce_qp_context_table_if.sv
// Bundle of every non-clock/reset signal of roce_qp_context_table.
//   s_cfg_*   host open/close configuration stream (valid/ready)
//   s_meta_*  TX DMA metadata stream (valid/ready)
//   s_ack_*   RX ACK/NAK stream (valid/ready)
//   rd_req_*  context read request, rd_rsp_* read response (latency 2)
//   m_retx_*  retransmit request pulse
//   err_*     error pulses
//   pmtu      path MTU code (0..4 = 256..4096 B)
// Modport slave is the context table side, master is the driving side.
interface roce_qp_context_table_if;
    logic        s_cfg_valid;
    logic        s_cfg_ready;
    logic        s_cfg_open;
    logic [23:0] s_cfg_loc_qpn;
    logic [23:0] s_cfg_rem_qpn;
    logic [23:0] s_cfg_loc_psn;
    logic [23:0] s_cfg_rem_psn;
    logic [31:0] s_cfg_rem_ip_addr;
    logic [63:0] s_cfg_rem_addr;
    logic [31:0] s_cfg_r_key;

    logic        s_meta_valid;
    logic        s_meta_ready;
    logic [23:0] s_meta_loc_qpn;
    logic [31:0] s_meta_dma_length;

    logic        s_ack_valid;
    logic        s_ack_ready;
    logic [23:0] s_ack_dest_qp;
    logic [23:0] s_ack_psn;
    logic [7:0]  s_ack_syndrome;

    logic        rd_req_valid;
    logic [23:0] rd_req_loc_qpn;
    logic        rd_rsp_valid;
    logic [2:0]  rd_rsp_state;
    logic [23:0] rd_rsp_rem_qpn;
    logic [23:0] rd_rsp_loc_qpn;
    logic [23:0] rd_rsp_next_psn;
    logic [23:0] rd_rsp_acked_psn;
    logic [31:0] rd_rsp_rem_ip_addr;
    logic [63:0] rd_rsp_rem_addr;
    logic [31:0] rd_rsp_r_key;
    logic [7:0]  rd_rsp_syndrome;

    logic        m_retx_valid;
    logic [23:0] m_retx_loc_qpn;
    logic [23:0] m_retx_psn;

    logic        err_invalid_qpn;
    logic        err_qp_state;
    logic [2:0]  pmtu;

    modport slave (
        input  s_cfg_valid, s_cfg_open, s_cfg_loc_qpn, s_cfg_rem_qpn, s_cfg_loc_psn,
               s_cfg_rem_psn, s_cfg_rem_ip_addr, s_cfg_rem_addr, s_cfg_r_key,
        output s_cfg_ready,
        input  s_meta_valid, s_meta_loc_qpn, s_meta_dma_length,
        output s_meta_ready,
        input  s_ack_valid, s_ack_dest_qp, s_ack_psn, s_ack_syndrome,
        output s_ack_ready,
        input  rd_req_valid, rd_req_loc_qpn,
        output rd_rsp_valid, rd_rsp_state, rd_rsp_rem_qpn, rd_rsp_loc_qpn, rd_rsp_next_psn,
               rd_rsp_acked_psn, rd_rsp_rem_ip_addr, rd_rsp_rem_addr, rd_rsp_r_key,
               rd_rsp_syndrome,
        output m_retx_valid, m_retx_loc_qpn, m_retx_psn,
        output err_invalid_qpn, err_qp_state,
        input  pmtu
    );

    modport master (
        output s_cfg_valid, s_cfg_open, s_cfg_loc_qpn, s_cfg_rem_qpn, s_cfg_loc_psn,
               s_cfg_rem_psn, s_cfg_rem_ip_addr, s_cfg_rem_addr, s_cfg_r_key,
        input  s_cfg_ready,
        output s_meta_valid, s_meta_loc_qpn, s_meta_dma_length,
        input  s_meta_ready,
        output s_ack_valid, s_ack_dest_qp, s_ack_psn, s_ack_syndrome,
        input  s_ack_ready,
        output rd_req_valid, rd_req_loc_qpn,
        input  rd_rsp_valid, rd_rsp_state, rd_rsp_rem_qpn, rd_rsp_loc_qpn, rd_rsp_next_psn,
               rd_rsp_acked_psn, rd_rsp_rem_ip_addr, rd_rsp_rem_addr, rd_rsp_r_key,
               rd_rsp_syndrome,
        input  m_retx_valid, m_retx_loc_qpn, m_retx_psn,
        input  err_invalid_qpn, err_qp_state,
        output pmtu
    );
endinterface

// File: rtl/roce_qp_context_table.sv
// Multi-QP context store with per-QP RESET/RTS/ERROR state for the RoCEv2 TX/RX path.
// Ports:
//   i_clk    single clock
//   i_rst_n  asynchronous active-low reset
//   io_qp    roce_qp_context_table_if.slave: cfg/meta/ack update streams (fixed priority
//            ack > meta > cfg, one beat per cycle), 2-cycle context read port,
//            retransmit pulse, error pulses, pmtu.
module roce_qp_context_table #(
    parameter int unsigned MAX_QUEUE_PAIRS = 8,
    parameter logic [23:0] QPN_BASE        = 24'h100
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    roce_qp_context_table_if.slave          io_qp
);

    localparam int unsigned IDX_W = $clog2(MAX_QUEUE_PAIRS);

    typedef enum logic [2:0] {
        StReset = 3'd0,
        StRts   = 3'd2,
        StError = 3'd3
    } qp_state_e;

    // Context storage
    qp_state_e   r_state      [MAX_QUEUE_PAIRS];
    logic [23:0] r_rem_qpn    [MAX_QUEUE_PAIRS];
    logic [23:0] r_loc_qpn    [MAX_QUEUE_PAIRS];
    logic [23:0] r_next_psn   [MAX_QUEUE_PAIRS];
    logic [23:0] r_acked_psn  [MAX_QUEUE_PAIRS];
    logic [31:0] r_rem_ip     [MAX_QUEUE_PAIRS];
    logic [63:0] r_rem_addr   [MAX_QUEUE_PAIRS];
    logic [31:0] r_r_key      [MAX_QUEUE_PAIRS];
    logic [7:0]  r_syndrome   [MAX_QUEUE_PAIRS];

    // ---------------- Arbiter: ack > meta > cfg ----------------
    logic w_ack_rdy, w_meta_rdy, w_cfg_rdy;
    assign w_ack_rdy  = i_rst_n & io_qp.s_ack_valid;
    assign w_meta_rdy = i_rst_n & io_qp.s_meta_valid & ~io_qp.s_ack_valid;
    assign w_cfg_rdy  = i_rst_n & io_qp.s_cfg_valid & ~io_qp.s_ack_valid & ~io_qp.s_meta_valid;

    assign io_qp.s_ack_ready  = w_ack_rdy;
    assign io_qp.s_meta_ready = w_meta_rdy;
    assign io_qp.s_cfg_ready  = w_cfg_rdy;

    // ---------------- Beat QPN decode ----------------
    logic [23:0]      w_beat_qpn;
    logic [23:0]      w_beat_off;
    logic             w_beat_hit;
    logic [IDX_W-1:0] w_beat_idx;

    assign w_beat_qpn = w_ack_rdy  ? io_qp.s_ack_dest_qp  :
                        w_meta_rdy ? io_qp.s_meta_loc_qpn : io_qp.s_cfg_loc_qpn;
    assign w_beat_off = w_beat_qpn - QPN_BASE;
    assign w_beat_hit = w_beat_off < 24'(MAX_QUEUE_PAIRS);
    assign w_beat_idx = w_beat_off[IDX_W-1:0];

    // ---------------- Packet count for a DMA transfer ----------------
    logic [2:0]  w_pmtu_eff;
    logic [3:0]  w_shift;
    logic [32:0] w_pkt_mask;
    logic [32:0] w_len_rnd;
    logic [23:0] w_npkts;

    assign w_pmtu_eff = (io_qp.pmtu > 3'd4) ? 3'd4 : io_qp.pmtu;
    assign w_shift    = {1'b0, w_pmtu_eff} + 4'd8;
    assign w_pkt_mask = (33'd1 << w_shift) - 33'd1;
    assign w_len_rnd  = {1'b0, io_qp.s_meta_dma_length} + w_pkt_mask;
    // Truncation to 24 bits is harmless: PSN arithmetic is modulo 2^24 anyway.
    assign w_npkts    = (io_qp.s_meta_dma_length == 32'd0) ? 24'd1 : 24'(w_len_rnd >> w_shift);

    // Local start PSN has no stored field; the TX sequence starts at the remote-supplied PSN.
    logic w_unused_loc_psn;
    assign w_unused_loc_psn = ^io_qp.s_cfg_loc_psn;

    // ---------------- Next-context computation ----------------
    qp_state_e   w_cur_state;
    qp_state_e   w_nxt_state;
    logic [23:0] w_nxt_rem_qpn, w_nxt_loc_qpn, w_nxt_next_psn, w_nxt_acked_psn;
    logic [31:0] w_nxt_rem_ip, w_nxt_r_key;
    logic [63:0] w_nxt_rem_addr;
    logic [7:0]  w_nxt_syndrome;
    logic        w_we;
    logic        w_err_inv;
    logic        w_err_st;
    logic        w_retx;

    assign w_cur_state = r_state[w_beat_idx];

    always_comb begin
        w_we            = 1'b0;
        w_err_inv       = 1'b0;
        w_err_st        = 1'b0;
        w_retx          = 1'b0;
        w_nxt_state     = w_cur_state;
        w_nxt_rem_qpn   = r_rem_qpn[w_beat_idx];
        w_nxt_loc_qpn   = r_loc_qpn[w_beat_idx];
        w_nxt_next_psn  = r_next_psn[w_beat_idx];
        w_nxt_acked_psn = r_acked_psn[w_beat_idx];
        w_nxt_rem_ip    = r_rem_ip[w_beat_idx];
        w_nxt_rem_addr  = r_rem_addr[w_beat_idx];
        w_nxt_r_key     = r_r_key[w_beat_idx];
        w_nxt_syndrome  = r_syndrome[w_beat_idx];

        if ((w_ack_rdy | w_meta_rdy | w_cfg_rdy) && !w_beat_hit) begin
            w_err_inv = 1'b1;
        end else if (w_ack_rdy) begin
            // ACK/NAK on a non-RTS QP is dropped without error.
            if (w_cur_state == StRts) begin
                case (io_qp.s_ack_syndrome[6:5])
                    2'b00: begin
                        w_we            = 1'b1;
                        w_nxt_acked_psn = io_qp.s_ack_psn;
                    end
                    2'b11: begin
                        if (io_qp.s_ack_syndrome[4:0] == 5'd0) begin
                            w_retx = 1'b1;
                        end else begin
                            w_we           = 1'b1;
                            w_nxt_state    = StError;
                            w_nxt_syndrome = io_qp.s_ack_syndrome;
                        end
                    end
                    default: ; // RNR and reserved codes are ignored
                endcase
            end
        end else if (w_meta_rdy) begin
            if (w_cur_state == StRts) begin
                w_we           = 1'b1;
                w_nxt_next_psn = r_next_psn[w_beat_idx] + w_npkts;
            end else begin
                w_err_st = 1'b1;
            end
        end else if (w_cfg_rdy) begin
            if (!io_qp.s_cfg_open) begin
                w_we            = 1'b1;
                w_nxt_state     = StReset;
                w_nxt_rem_qpn   = '0;
                w_nxt_loc_qpn   = '0;
                w_nxt_next_psn  = '0;
                w_nxt_acked_psn = '0;
                w_nxt_rem_ip    = '0;
                w_nxt_rem_addr  = '0;
                w_nxt_r_key     = '0;
                w_nxt_syndrome  = '0;
            end else if (w_cur_state == StRts) begin
                w_err_st = 1'b1;
            end else begin
                w_we            = 1'b1;
                w_nxt_state     = StRts;
                w_nxt_rem_qpn   = io_qp.s_cfg_rem_qpn;
                w_nxt_loc_qpn   = io_qp.s_cfg_loc_qpn;
                w_nxt_next_psn  = io_qp.s_cfg_rem_psn;
                w_nxt_acked_psn = io_qp.s_cfg_rem_psn - 24'd1;
                w_nxt_rem_ip    = io_qp.s_cfg_rem_ip_addr;
                w_nxt_rem_addr  = io_qp.s_cfg_rem_addr;
                w_nxt_r_key     = io_qp.s_cfg_r_key;
                w_nxt_syndrome  = '0;
            end
        end
    end

    // ---------------- Context register file ----------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < MAX_QUEUE_PAIRS; i++) begin
                r_state[i]     <= StReset;
                r_rem_qpn[i]   <= '0;
                r_loc_qpn[i]   <= '0;
                r_next_psn[i]  <= '0;
                r_acked_psn[i] <= '0;
                r_rem_ip[i]    <= '0;
                r_rem_addr[i]  <= '0;
                r_r_key[i]     <= '0;
                r_syndrome[i]  <= '0;
            end
        end else if (w_we) begin
            r_state[w_beat_idx]     <= w_nxt_state;
            r_rem_qpn[w_beat_idx]   <= w_nxt_rem_qpn;
            r_loc_qpn[w_beat_idx]   <= w_nxt_loc_qpn;
            r_next_psn[w_beat_idx]  <= w_nxt_next_psn;
            r_acked_psn[w_beat_idx] <= w_nxt_acked_psn;
            r_rem_ip[w_beat_idx]    <= w_nxt_rem_ip;
            r_rem_addr[w_beat_idx]  <= w_nxt_rem_addr;
            r_r_key[w_beat_idx]     <= w_nxt_r_key;
            r_syndrome[w_beat_idx]  <= w_nxt_syndrome;
        end
    end

    // ---------------- Read port, pulses ----------------
    logic [23:0]      w_rd_off;
    logic             w_rd_hit;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_rd_off = io_qp.rd_req_loc_qpn - QPN_BASE;
    assign w_rd_hit = w_rd_off < 24'(MAX_QUEUE_PAIRS);
    assign w_rd_idx = w_rd_off[IDX_W-1:0];

    logic             r_rd_p1_valid;
    logic [IDX_W-1:0] r_rd_p1_idx;
    logic             r_rsp_valid;
    logic [2:0]       r_rsp_state;
    logic [23:0]      r_rsp_rem_qpn, r_rsp_loc_qpn, r_rsp_next_psn, r_rsp_acked_psn;
    logic [31:0]      r_rsp_rem_ip, r_rsp_r_key;
    logic [63:0]      r_rsp_rem_addr;
    logic [7:0]       r_rsp_syndrome;
    logic             r_retx_valid;
    logic [23:0]      r_retx_qpn, r_retx_psn;
    logic             r_err_inv, r_err_st;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_p1_valid   <= 1'b0;
            r_rd_p1_idx     <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_state     <= '0;
            r_rsp_rem_qpn   <= '0;
            r_rsp_loc_qpn   <= '0;
            r_rsp_next_psn  <= '0;
            r_rsp_acked_psn <= '0;
            r_rsp_rem_ip    <= '0;
            r_rsp_rem_addr  <= '0;
            r_rsp_r_key     <= '0;
            r_rsp_syndrome  <= '0;
            r_retx_valid    <= 1'b0;
            r_retx_qpn      <= '0;
            r_retx_psn      <= '0;
            r_err_inv       <= 1'b0;
            r_err_st        <= 1'b0;
        end else begin
            r_rd_p1_valid <= io_qp.rd_req_valid & w_rd_hit;
            r_rd_p1_idx   <= w_rd_idx;
            r_rsp_valid   <= r_rd_p1_valid;
            // Array is read one cycle after the request, so beats landing on the
            // request edge are also visible.
            if (r_rd_p1_valid) begin
                r_rsp_state     <= r_state[r_rd_p1_idx];
                r_rsp_rem_qpn   <= r_rem_qpn[r_rd_p1_idx];
                r_rsp_loc_qpn   <= r_loc_qpn[r_rd_p1_idx];
                r_rsp_next_psn  <= r_next_psn[r_rd_p1_idx];
                r_rsp_acked_psn <= r_acked_psn[r_rd_p1_idx];
                r_rsp_rem_ip    <= r_rem_ip[r_rd_p1_idx];
                r_rsp_rem_addr  <= r_rem_addr[r_rd_p1_idx];
                r_rsp_r_key     <= r_r_key[r_rd_p1_idx];
                r_rsp_syndrome  <= r_syndrome[r_rd_p1_idx];
            end
            r_retx_valid <= w_retx;
            if (w_retx) begin
                r_retx_qpn <= io_qp.s_ack_dest_qp;
                r_retx_psn <= io_qp.s_ack_psn;
            end
            r_err_inv <= w_err_inv | (io_qp.rd_req_valid & ~w_rd_hit);
            r_err_st  <= w_err_st;
        end
    end

    assign io_qp.rd_rsp_valid       = r_rsp_valid;
    assign io_qp.rd_rsp_state       = r_rsp_state;
    assign io_qp.rd_rsp_rem_qpn     = r_rsp_rem_qpn;
    assign io_qp.rd_rsp_loc_qpn     = r_rsp_loc_qpn;
    assign io_qp.rd_rsp_next_psn    = r_rsp_next_psn;
    assign io_qp.rd_rsp_acked_psn   = r_rsp_acked_psn;
    assign io_qp.rd_rsp_rem_ip_addr = r_rsp_rem_ip;
    assign io_qp.rd_rsp_rem_addr    = r_rsp_rem_addr;
    assign io_qp.rd_rsp_r_key       = r_rsp_r_key;
    assign io_qp.rd_rsp_syndrome    = r_rsp_syndrome;
    assign io_qp.m_retx_valid       = r_retx_valid;
    assign io_qp.m_retx_loc_qpn     = r_retx_qpn;
    assign io_qp.m_retx_psn         = r_retx_psn;
    assign io_qp.err_invalid_qpn    = r_err_inv;
    assign io_qp.err_qp_state       = r_err_st;

endmodule

// File: tb/tb_roce_qp_context_table.sv
// Self-checking bench for roce_qp_context_table: a reference context model predicts
// each read response, which is queued at request time and compared on arrival.
module tb_roce_qp_context_table;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    roce_qp_context_table_if bus ();

    roce_qp_context_table #(
        .MAX_QUEUE_PAIRS (8),
        .QPN_BASE        (24'h100)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_qp   (bus)
    );

    typedef struct {
        logic [2:0]  st;
        logic [23:0] rem_qpn;
        logic [23:0] loc_qpn;
        logic [23:0] next_psn;
        logic [23:0] acked_psn;
        logic [31:0] ip;
        logic [63:0] addr;
        logic [31:0] rkey;
        logic [7:0]  syn;
    } exp_t;

    exp_t sb[$];
    exp_t model[8];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qidx(input logic [23:0] q);
        if (q >= 24'h100 && q < 24'h108) return int'(q - 24'h100);
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            model[i] = '{3'd0, 24'd0, 24'd0, 24'd0, 24'd0, 32'd0, 64'd0, 32'd0, 8'd0};
        end
    endtask

    // which: 0=ack 1=meta 2=cfg
    task automatic handshake(input int which, input string tag);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            case (which)
                0:       seen = bus.s_ack_ready;
                1:       seen = bus.s_meta_ready;
                default: seen = bus.s_cfg_ready;
            endcase
        end
        check({tag, "_ready"}, 64'(seen), 64'd1);
        @(posedge clk); #1;
        case (which)
            0:       bus.s_ack_valid = 1'b0;
            1:       bus.s_meta_valid = 1'b0;
            default: bus.s_cfg_valid = 1'b0;
        endcase
    endtask

    task automatic check_pulses(input string tag, input logic e_inv, input logic e_st,
                                input logic e_retx, input logic [23:0] e_rq,
                                input logic [23:0] e_rp);
        @(negedge clk);
        check({tag, "_err_inv"}, 64'(bus.err_invalid_qpn), 64'(e_inv));
        check({tag, "_err_st"}, 64'(bus.err_qp_state), 64'(e_st));
        check({tag, "_retx_v"}, 64'(bus.m_retx_valid), 64'(e_retx));
        if (e_retx) begin
            check({tag, "_retx_qpn"}, 64'(bus.m_retx_loc_qpn), 64'(e_rq));
            check({tag, "_retx_psn"}, 64'(bus.m_retx_psn), 64'(e_rp));
        end
        @(posedge clk); #1;
    endtask

    task automatic cfg_beat(input logic open, input logic [23:0] qpn, input logic [23:0] rq,
                            input logic [23:0] rpsn, input logic [31:0] ip,
                            input logic [63:0] addr, input logic [31:0] rk);
        int i;
        logic einv, est;
        i = qidx(qpn);
        einv = 1'b0;
        est = 1'b0;
        bus.s_cfg_open = open;
        bus.s_cfg_loc_qpn = qpn;
        bus.s_cfg_rem_qpn = rq;
        bus.s_cfg_loc_psn = 24'h0;
        bus.s_cfg_rem_psn = rpsn;
        bus.s_cfg_rem_ip_addr = ip;
        bus.s_cfg_rem_addr = addr;
        bus.s_cfg_r_key = rk;
        bus.s_cfg_valid = 1'b1;
        handshake(2, "cfg");
        if (i < 0) einv = 1'b1;
        else if (!open) model[i] = '{3'd0, 24'd0, 24'd0, 24'd0, 24'd0, 32'd0, 64'd0, 32'd0, 8'd0};
        else if (model[i].st == 3'd2) est = 1'b1;
        else model[i] = '{3'd2, rq, qpn, rpsn, rpsn - 24'd1, ip, addr, rk, 8'd0};
        check_pulses("cfg", einv, est, 1'b0, 24'd0, 24'd0);
    endtask

    task automatic meta_beat(input logic [23:0] qpn, input logic [31:0] len);
        int i;
        logic einv, est;
        longint pkt, np;
        i = qidx(qpn);
        einv = 1'b0;
        est = 1'b0;
        bus.s_meta_loc_qpn = qpn;
        bus.s_meta_dma_length = len;
        bus.s_meta_valid = 1'b1;
        handshake(1, "meta");
        pkt = 64'd256 << ((bus.pmtu > 3'd4) ? 4 : int'(bus.pmtu));
        np = (len == 32'd0) ? 1 : (longint'(len) + pkt - 1) / pkt;
        if (i < 0) einv = 1'b1;
        else if (model[i].st != 3'd2) est = 1'b1;
        else model[i].next_psn = model[i].next_psn + 24'(np);
        check_pulses("meta", einv, est, 1'b0, 24'd0, 24'd0);
    endtask

    task automatic ack_beat(input logic [23:0] qpn, input logic [23:0] psn, input logic [7:0] syn);
        int i;
        logic einv, eretx;
        i = qidx(qpn);
        einv = 1'b0;
        eretx = 1'b0;
        bus.s_ack_dest_qp = qpn;
        bus.s_ack_psn = psn;
        bus.s_ack_syndrome = syn;
        bus.s_ack_valid = 1'b1;
        handshake(0, "ack");
        if (i < 0) einv = 1'b1;
        else if (model[i].st == 3'd2) begin
            if (syn[6:5] == 2'b00) model[i].acked_psn = psn;
            else if (syn[6:5] == 2'b11 && syn[4:0] == 5'd0) eretx = 1'b1;
            else if (syn[6:5] == 2'b11) begin
                model[i].st = 3'd3;
                model[i].syn = syn;
            end
        end
        check_pulses("ack", einv, 1'b0, eretx, qpn, psn);
    endtask

    task automatic rd(input logic [23:0] qpn, input string tag);
        int i;
        int lat;
        logic got, inv1;
        exp_t e;
        i = qidx(qpn);
        got = 1'b0;
        inv1 = 1'b0;
        lat = 0;
        if (i >= 0) sb.push_back(model[i]);
        bus.rd_req_loc_qpn = qpn;
        bus.rd_req_valid = 1'b1;
        @(posedge clk); #1;
        bus.rd_req_valid = 1'b0;
        for (int n = 1; n <= 5 && !got; n++) begin
            @(negedge clk);
            if (n == 1) inv1 = bus.err_invalid_qpn;
            if (bus.rd_rsp_valid) begin
                got = 1'b1;
                lat = n;
            end
        end
        check({tag, "_err_inv"}, 64'(inv1), 64'(i < 0));
        if (i < 0) begin
            check({tag, "_no_rsp"}, 64'(got), 64'd0);
        end else begin
            check({tag, "_rsp_seen"}, 64'(got), 64'd1);
            check({tag, "_latency"}, 64'(lat), 64'd2);
            e = sb.pop_front();
            check({tag, "_state"}, 64'(bus.rd_rsp_state), 64'(e.st));
            check({tag, "_rem_qpn"}, 64'(bus.rd_rsp_rem_qpn), 64'(e.rem_qpn));
            check({tag, "_loc_qpn"}, 64'(bus.rd_rsp_loc_qpn), 64'(e.loc_qpn));
            check({tag, "_next_psn"}, 64'(bus.rd_rsp_next_psn), 64'(e.next_psn));
            check({tag, "_acked_psn"}, 64'(bus.rd_rsp_acked_psn), 64'(e.acked_psn));
            check({tag, "_ip"}, 64'(bus.rd_rsp_rem_ip_addr), 64'(e.ip));
            check({tag, "_addr"}, bus.rd_rsp_rem_addr, e.addr);
            check({tag, "_rkey"}, 64'(bus.rd_rsp_r_key), 64'(e.rkey));
            check({tag, "_syn"}, 64'(bus.rd_rsp_syndrome), 64'(e.syn));
            @(negedge clk);
            check({tag, "_rsp_pulse"}, 64'(bus.rd_rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_cfg_valid = 1'b0;
        bus.s_cfg_open = 1'b0;
        bus.s_cfg_loc_qpn = '0;
        bus.s_cfg_rem_qpn = '0;
        bus.s_cfg_loc_psn = '0;
        bus.s_cfg_rem_psn = '0;
        bus.s_cfg_rem_ip_addr = '0;
        bus.s_cfg_rem_addr = '0;
        bus.s_cfg_r_key = '0;
        bus.s_meta_valid = 1'b0;
        bus.s_meta_loc_qpn = '0;
        bus.s_meta_dma_length = '0;
        bus.s_ack_valid = 1'b1;  // readies must stay low while in reset
        bus.s_ack_dest_qp = 24'h100;
        bus.s_ack_psn = '0;
        bus.s_ack_syndrome = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_loc_qpn = '0;
        bus.pmtu = 3'd2;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack_ready", 64'(bus.s_ack_ready), 64'd0);
        bus.s_ack_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
        check("rst_retx", 64'(bus.m_retx_valid), 64'd0);
        check("rst_err_inv", 64'(bus.err_invalid_qpn), 64'd0);
        check("rst_err_st", 64'(bus.err_qp_state), 64'd0);
        @(posedge clk); #1;
        rd(24'h103, "rd_rst");

        // 1: open and read back
        cfg_beat(1'b1, 24'h101, 24'h0A0B0C, 24'h000010, 32'hC0A80002,
                 64'h0000_1234_5678_9ABC, 32'hDEADBEEF);
        rd(24'h101, "rd_open");

        // 2: PSN advance and wrap
        meta_beat(24'h101, 32'd4096);
        meta_beat(24'h101, 32'd4097);
        meta_beat(24'h101, 32'd0);
        rd(24'h101, "rd_meta");
        cfg_beat(1'b1, 24'h102, 24'h000777, 24'hFFFFFE, 32'h0A000001, 64'hFFFF_0000_0000_1000,
                 32'h12345678);
        meta_beat(24'h102, 32'd1024);
        rd(24'h102, "rd_wrap1");
        meta_beat(24'h102, 32'd3072);
        rd(24'h102, "rd_wrap2");
        bus.pmtu = 3'd7;
        meta_beat(24'h102, 32'd8192);
        bus.pmtu = 3'd2;
        rd(24'h102, "rd_pmtu_clamp");

        // 3: ACK / NAK handling
        ack_beat(24'h101, 24'h000020, 8'h1F);
        rd(24'h101, "rd_ack");
        ack_beat(24'h101, 24'h000021, 8'h60);
        ack_beat(24'h101, 24'h000025, 8'h20);
        rd(24'h101, "rd_seq_nak");
        ack_beat(24'h101, 24'h000022, 8'h62);
        rd(24'h101, "rd_fatal");
        ack_beat(24'h101, 24'h000030, 8'h00);
        meta_beat(24'h101, 32'd100);
        rd(24'h101, "rd_err_hold");

        // 4: simultaneous sources on QP 0x100
        cfg_beat(1'b1, 24'h100, 24'h000055, 24'h000500, 32'h01020304, 64'h0, 32'h0000_0001);
        bus.s_ack_dest_qp = 24'h100;
        bus.s_ack_psn = 24'h000500;
        bus.s_ack_syndrome = 8'h00;
        bus.s_meta_loc_qpn = 24'h100;
        bus.s_meta_dma_length = 32'd300;
        bus.s_cfg_open = 1'b1;
        bus.s_cfg_loc_qpn = 24'h100;
        bus.s_ack_valid = 1'b1;
        bus.s_meta_valid = 1'b1;
        bus.s_cfg_valid = 1'b1;
        @(negedge clk);
        check("arb_c1", 64'({bus.s_ack_ready, bus.s_meta_ready, bus.s_cfg_ready}), 64'd4);
        @(posedge clk); #1;
        bus.s_ack_valid = 1'b0;
        @(negedge clk);
        check("arb_c2", 64'({bus.s_ack_ready, bus.s_meta_ready, bus.s_cfg_ready}), 64'd2);
        @(posedge clk); #1;
        bus.s_meta_valid = 1'b0;
        @(negedge clk);
        check("arb_c3", 64'({bus.s_ack_ready, bus.s_meta_ready, bus.s_cfg_ready}), 64'd1);
        @(posedge clk); #1;
        bus.s_cfg_valid = 1'b0;
        @(negedge clk);
        check("arb_cfg_err_st", 64'(bus.err_qp_state), 64'd1);
        @(posedge clk); #1;
        model[0].acked_psn = 24'h000500;
        model[0].next_psn = 24'h000501;
        rd(24'h100, "rd_arb");

        // 5: illegal commands, out-of-range, close/reopen
        cfg_beat(1'b1, 24'h101, 24'h000111, 24'h000900, 32'h0, 64'h0, 32'h0);
        rd(24'h101, "rd_reopen_err");
        cfg_beat(1'b1, 24'h101, 24'h000222, 24'h000A00, 32'h5, 64'h6, 32'h7);
        rd(24'h101, "rd_open_rts");
        meta_beat(24'h200, 32'd64);
        ack_beat(24'h300, 24'h1, 8'h0);
        rd(24'h0FF, "rd_oor");
        cfg_beat(1'b0, 24'h101, 24'h0, 24'h0, 32'h0, 64'h0, 32'h0);
        rd(24'h101, "rd_closed");
        cfg_beat(1'b1, 24'h101, 24'h000333, 24'h000B00, 32'h8, 64'h9, 32'hA);
        rd(24'h101, "rd_reopen");

        // 6: reset between request and response
        sb.push_back(model[1]);
        bus.rd_req_loc_qpn = 24'h101;
        bus.rd_req_valid = 1'b1;
        @(posedge clk); #2;
        bus.rd_req_valid = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("rst_flush_rsp", 64'(bus.rd_rsp_valid), 64'd0);
        end
        @(posedge clk); #1;
        for (int q = 0; q < 8; q++) begin
            rd(24'h100 + 24'(q), "rd_after_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
